xor_pulse_tx: RTL
=================

Name: xor_pulse_tx

Overview:
- Synchronous transmitter that drives the edge-encoded pulse inputs (a, b, clk) of the basic XOR cell model from a valid/ready stream of bit pairs.
- Each accepted symbol (in_a, in_b) becomes a toggle on a_out if in_a=1, then a toggle on b_out if in_b=1, then always a toggle on clk_out.
- Consecutive toggles are spaced so the cell's critical-timing hold checks are never violated.
- Sits in the bench/stimulus layer, upstream of the cell; also tracks the expected cell output level.

Parameters:
- GAP_CYCLES, 3, clock cycles between successive toggles within a symbol; legal range 1..255.
- CNT_W, 16, width of the symbol counter and of the error counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  symbol offered.
- in_ready  output  1  transmitter can accept a symbol.
- in_a  input  1  symbol bit a.
- in_b  input  1  symbol bit b.
- a_out  output  1  level line to cell input a; each toggle is one pulse.
- b_out  output  1  level line to cell input b.
- clk_out  output  1  level line to cell input clk.
- busy  output  1  symbol in flight (state != IDLE).
- expect_out  output  1  expected cell out level after the last completed symbol.
- sym_count  output  CNT_W  completed symbols.

Behaviour:
- Reset (async, rst=1):
  - a_out, b_out, clk_out, expect_out, busy = 0; sym_count = 0; in_ready = 1; FSM = IDLE; gap counter = 0.
  - These values match the cell's power-up state (out=0).
- FSM states: IDLE, GAP_A, GAP_B, GAP_CLK.
  - in_ready = 1 only in IDLE. busy = !in_ready.
- Accept: on an edge T in IDLE with in_valid=1, latch in_a and in_b. Then:
  - in_a=1: toggle a_out at edge T; go to GAP_A; load counter = GAP_CYCLES-1.
  - in_a=0, in_b=1: toggle b_out at edge T; go to GAP_B.
  - in_a=0, in_b=0: toggle clk_out at edge T; go to GAP_CLK.
- GAP_x: decrement the counter each edge. On the edge where the counter is 0:
  - GAP_A: toggle b_out if the latched b=1 and go to GAP_B; otherwise toggle clk_out and go to GAP_CLK. Reload the counter.
  - GAP_B: toggle clk_out and go to GAP_CLK. Reload the counter.
  - GAP_CLK: return to IDLE.
- Toggle spacing:
  - Within a symbol, successive toggles are exactly GAP_CYCLES edges apart.
  - Symbol occupancy is (1 + a + b) * GAP_CYCLES cycles, plus 1 idle cycle before the next accept can occur.
  - The minimum spacing between the last toggle of one symbol and the first toggle of the next is GAP_CYCLES+1.
- On the clk_out toggle edge:
  - sym_count increments, wrapping modulo 2^CNT_W.
  - expect_out ^= (a ^ b).
- in_a and in_b are ignored outside the accepting edge. in_valid held high with in_ready=0 has no effect.
- Reset asserted mid-symbol: the partial symbol is discarded and all outputs return to reset values immediately. The downstream cell must be re-initialised by the bench.
- Only one output line toggles on any given edge.

Optional Feature:
- Macro: XOR_PULSE_TX_CHECK_EN.
- Defined:
  - Adds ports: dut_out input 1 (cell out); mismatch output 1 (sticky); err_count output CNT_W.
  - On the edge leaving GAP_CLK, dut_out is compared with expect_out.
  - On inequality: mismatch is set and err_count increments, saturating at all-ones.
  - Both mismatch and err_count are cleared only by rst.
  - GAP_CYCLES must cover the cell clk->out delay in clock periods.
- Undefined: these ports and this logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, no input -> in_ready=1; a_out, b_out, clk_out, expect_out=0; sym_count=0.
- GAP_CYCLES=3; accept (1,1) at edge T -> a_out toggles at T, b_out at T+3, clk_out at T+6; in_ready=1 after T+9; expect_out stays 0; sym_count=1.
- Back-to-back symbols (1,0), (0,1), (0,0) with in_valid held high -> expect_out sequence 1, 0, 0; clk_out toggles 3 times; no two toggles closer than 3 edges; sym_count=3.
- Reset asserted one cycle after accepting (1,1) -> all outputs 0 asynchronously, FSM IDLE, no b_out or clk_out toggle; after release, symbol (0,0) completes normally with sym_count=1.
- CNT_W=4, 17 symbols of (1,0) -> sym_count wraps to 1; expect_out=1.
- XOR_PULSE_TX_CHECK_EN defined, dut_out forced to 0, symbol (1,0) -> mismatch=1 and err_count=1 on the edge leaving GAP_CLK; a following (1,0) with dut_out=0 matches expect_out=0, so err_count stays 1.

Source files
------------

// File: rtl/xor_pulse_tx.sv
// xor_pulse_tx: turns a valid/ready stream of (a, b) bit pairs into edge-encoded
// pulses on the a/b/clk inputs of the XOR cell model. Each toggle is one pulse,
// and toggles are spaced GAP_CYCLES edges apart. The block also tracks the cell
// output level expected after each completed symbol.
//
// Optional feature (define XOR_PULSE_TX_CHECK_EN): this adds the dut_out input
// and the mismatch/err_count outputs. The cell output is compared against
// expect_out on the edge that leaves GAP_CLK.
module xor_pulse_tx #(
    parameter int GAP_CYCLES = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    output logic             a_out,
    output logic             b_out,
    output logic             clk_out,
    output logic             busy,
    output logic             expect_out,
    output logic [CNT_W-1:0] sym_count
`ifdef XOR_PULSE_TX_CHECK_EN
    ,
    input  logic             dut_out,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count
`endif
);

    // The gap counter is loaded with GAP_CYCLES-1, so the next toggle lands
    // exactly GAP_CYCLES edges after the current one.
    localparam logic [7:0] RELOAD = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GAP_A,
        GAP_B,
        GAP_CLK
    } state_t;

    state_t     state;
    logic [7:0] gap_cnt;
    logic       lat_a;
    logic       lat_b;

    // Only IDLE accepts a symbol. Reset forces IDLE asynchronously, so ready
    // comes back at once when rst is asserted.
    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;

    // Pulse sequencer: emits a, then b, then clk toggles. It also updates the
    // expected output and the symbol counter on the clk toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gap_cnt    <= 8'd0;
            lat_a      <= 1'b0;
            lat_b      <= 1'b0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            clk_out    <= 1'b0;
            expect_out <= 1'b0;
            sym_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        lat_a   <= in_a;
                        lat_b   <= in_b;
                        gap_cnt <= RELOAD;
                        if (in_a) begin
                            a_out <= ~a_out;
                            state <= GAP_A;
                        end else if (in_b) begin
                            b_out <= ~b_out;
                            state <= GAP_B;
                        end else begin
                            // A symbol of (0,0) is a bare clock pulse. It has
                            // even parity, so the expected level is unchanged.
                            clk_out    <= ~clk_out;
                            sym_count  <= sym_count + CNT_W'(1);
                            expect_out <= expect_out ^ (in_a ^ in_b);
                            state      <= GAP_CLK;
                        end
                    end
                end
                GAP_A: begin
                    if (gap_cnt == 8'd0) begin
                        gap_cnt <= RELOAD;
                        if (lat_b) begin
                            b_out <= ~b_out;
                            state <= GAP_B;
                        end else begin
                            clk_out    <= ~clk_out;
                            sym_count  <= sym_count + CNT_W'(1);
                            expect_out <= expect_out ^ (lat_a ^ lat_b);
                            state      <= GAP_CLK;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                GAP_B: begin
                    if (gap_cnt == 8'd0) begin
                        gap_cnt    <= RELOAD;
                        clk_out    <= ~clk_out;
                        sym_count  <= sym_count + CNT_W'(1);
                        expect_out <= expect_out ^ (lat_a ^ lat_b);
                        state      <= GAP_CLK;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                GAP_CLK: begin
                    // This gap gives the cell time to settle after its clock
                    // pulse before the next symbol can start.
                    if (gap_cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef XOR_PULSE_TX_CHECK_EN
    // Compares the cell output on the edge that leaves GAP_CLK. The mismatch
    // flag is sticky, and the error count saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch  <= 1'b0;
            err_count <= '0;
        end else if (state == GAP_CLK && gap_cnt == 8'd0 && dut_out != expect_out) begin
            mismatch <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule
